bp_request_sequencer: RTL and testbench

// Client-side driver of the gshare predictor's start/done handshake. Takes prediction

---
 rtl/bp_request_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_bp_request_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_request_sequencer.sv
// bp_request_sequencer: client-side driver for the gshare predictor's start/done
// handshake. Holds one pending prediction and a FIFO of resolve updates, issues one
// operation at a time, holds operands until done, and aborts a silent predictor.
module bp_request_sequencer #(
  parameter int W        = 32,
  parameter int RQ_DEPTH = 4,
  parameter int TIMEOUT  = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  // fetch side
  input  logic         i_pred_req,
  input  logic [W-1:0] i_pred_pc,
  output logic         o_pred_ready,
  output logic         o_pred_resp_valid,
  output logic         o_pred_resp_taken,
  output logic [W-1:0] o_pred_resp_tgt,
  // execute side
  input  logic         i_res_valid,
  input  logic [W-1:0] i_res_pc,
  input  logic         i_res_taken,
  input  logic [W-1:0] i_res_tgt,
  output logic         o_res_ready,
  // predictor side
  output logic         o_start_pred,
  output logic         o_start_resolve,
  output logic [W-1:0] o_bp_pc,
  output logic         o_bp_taken,
  output logic [W-1:0] o_bp_tgt,
  input  logic         i_done,
  input  logic         i_bp_pred_taken,
  input  logic [W-1:0] i_bp_pred_tgt,
  // status
  output logic         o_busy,
  output logic         o_timeout_err
);

  localparam int PW = $clog2(RQ_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int EW = 2 * W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic            r_slot_full;
  logic [W-1:0]    r_slot_pc;

  logic [EW-1:0]   r_fifo [RQ_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic [1:0]      r_streak;
  logic            r_op_is_pred;
  logic [TW-1:0]   r_tmo;

  logic            r_start_pred;
  logic            r_start_resolve;
  logic [W-1:0]    r_bp_pc;
  logic            r_bp_taken;
  logic [W-1:0]    r_bp_tgt;
  logic            r_resp_valid;
  logic            r_resp_taken;
  logic [W-1:0]    r_resp_tgt;

  logic            w_push;
  logic            w_fifo_ne;
  logic [EW-1:0]   w_head;
  logic            w_issue_res;
  logic            w_issue_pred;
  logic            w_wait_done;
  logic            w_tmo_hit;

  // Ready comes from the registered count, so a push while full is simply not accepted.
  assign o_res_ready = (r_count != CW'(RQ_DEPTH));
  assign o_pred_ready = !r_slot_full;
  assign w_push = i_res_valid && o_res_ready;
  assign w_fifo_ne = (r_count != '0);
  assign w_head = r_fifo[r_rd_ptr];

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next state and issue arbitration: resolves first, but a waiting prediction wins
  // after two resolves in a row so fetch is never starved.
  always_comb begin
    w_state_next = r_state;
    w_issue_res  = 1'b0;
    w_issue_pred = 1'b0;
    w_wait_done  = 1'b0;
    w_tmo_hit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fifo_ne && !(r_slot_full && (r_streak == 2'd2))) begin
          w_issue_res  = 1'b1;
          w_state_next = S_ISSUE;
        end else if (r_slot_full) begin
          w_issue_pred = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT: begin
        if (i_done) begin
          w_wait_done  = 1'b1;
          w_state_next = S_IDLE;
        end else if (r_tmo == TW'(TIMEOUT)) begin
          w_tmo_hit    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Resolve FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= {i_res_pc, i_res_taken, i_res_tgt};
  end

  // Slot, FIFO bookkeeping, operand latching, start pulses, timeout counter, response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_full     <= 1'b0;
      r_slot_pc       <= '0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_streak        <= '0;
      r_op_is_pred    <= 1'b0;
      r_tmo           <= '0;
      r_start_pred    <= 1'b0;
      r_start_resolve <= 1'b0;
      r_bp_pc         <= '0;
      r_bp_taken      <= 1'b0;
      r_bp_tgt        <= '0;
      r_resp_valid    <= 1'b0;
      r_resp_taken    <= 1'b0;
      r_resp_tgt      <= '0;
    end else begin
      // pred slot: freed by issue; refill is impossible that cycle since ready was low
      if (w_issue_pred) begin
        r_slot_full <= 1'b0;
      end else if (i_pred_req && !r_slot_full) begin
        r_slot_full <= 1'b1;
        r_slot_pc   <= i_pred_pc;
      end

      if (w_push)      r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_issue_res) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_issue_res})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      if (w_issue_res) begin
        r_bp_pc      <= w_head[EW-1:W+1];
        r_bp_taken   <= w_head[W];
        r_bp_tgt     <= w_head[W-1:0];
        r_op_is_pred <= 1'b0;
        if (r_streak != 2'd2) r_streak <= r_streak + 2'd1;
      end else if (w_issue_pred) begin
        r_bp_pc      <= r_slot_pc;
        r_bp_taken   <= 1'b0;
        r_bp_tgt     <= '0;
        r_op_is_pred <= 1'b1;
        r_streak     <= '0;
      end

      r_start_pred    <= w_issue_pred;
      r_start_resolve <= w_issue_res;

      // counts 1 on the first WAIT cycle
      if (r_state == S_ISSUE)     r_tmo <= TW'(1);
      else if (r_state == S_WAIT) r_tmo <= r_tmo + TW'(1);

      r_resp_valid <= w_wait_done && r_op_is_pred;
      if (w_wait_done && r_op_is_pred) begin
        r_resp_taken <= i_bp_pred_taken;
        r_resp_tgt   <= i_bp_pred_tgt;
      end
    end
  end

  assign o_start_pred      = r_start_pred;
  assign o_start_resolve   = r_start_resolve;
  assign o_bp_pc           = r_bp_pc;
  assign o_bp_taken        = r_bp_taken;
  assign o_bp_tgt          = r_bp_tgt;
  assign o_pred_resp_valid = r_resp_valid;
  assign o_pred_resp_taken = r_resp_taken;
  assign o_pred_resp_tgt   = r_resp_tgt;
  assign o_busy            = (r_state != S_IDLE);
  assign o_timeout_err     = w_tmo_hit;

endmodule

// File: tb/tb_bp_request_sequencer.sv
// Directed bench for bp_request_sequencer with a small auto-responding predictor.
module tb_bp_request_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_pred_req, i_res_valid, i_res_taken, i_bp_pred_taken;
  logic [W-1:0] i_pred_pc, i_res_pc, i_res_tgt, i_bp_pred_tgt;
  logic         i_done;
  logic         o_pred_ready, o_pred_resp_valid, o_pred_resp_taken;
  logic [W-1:0] o_pred_resp_tgt, o_bp_pc, o_bp_tgt;
  logic         o_res_ready, o_start_pred, o_start_resolve, o_bp_taken;
  logic         o_busy, o_timeout_err;

  logic auto_en   = 1'b0;
  logic auto_done = 1'b0;
  logic man_done  = 1'b0;
  int   acnt      = 0;
  int   cyc       = 0;
  int   total     = 0;
  int   bad       = 0;

  assign i_done = auto_done | man_done;

  always #5 clk = ~clk;

  bp_request_sequencer #(.W(W), .RQ_DEPTH(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_pred_req(i_pred_req), .i_pred_pc(i_pred_pc), .o_pred_ready(o_pred_ready),
    .o_pred_resp_valid(o_pred_resp_valid), .o_pred_resp_taken(o_pred_resp_taken),
    .o_pred_resp_tgt(o_pred_resp_tgt),
    .i_res_valid(i_res_valid), .i_res_pc(i_res_pc), .i_res_taken(i_res_taken),
    .i_res_tgt(i_res_tgt), .o_res_ready(o_res_ready),
    .o_start_pred(o_start_pred), .o_start_resolve(o_start_resolve),
    .o_bp_pc(o_bp_pc), .o_bp_taken(o_bp_taken), .o_bp_tgt(o_bp_tgt),
    .i_done(i_done), .i_bp_pred_taken(i_bp_pred_taken), .i_bp_pred_tgt(i_bp_pred_tgt),
    .o_busy(o_busy), .o_timeout_err(o_timeout_err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Predictor model: start seen in cycle T -> done high during cycle T+2.
  always @(negedge clk) begin
    if (!auto_en) begin
      acnt = 0;
      auto_done = 1'b0;
    end else begin
      auto_done = 1'b0;
      if (acnt == 2) begin
        auto_done = 1'b1;
        acnt = 0;
      end else if (acnt == 1) begin
        acnt = 2;
      end else if (o_start_pred || o_start_resolve) begin
        acnt = 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_pred_req = 1'b0; i_res_valid = 1'b0; man_done = 1'b0; auto_en = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic issue_pred(input logic [W-1:0] pc);
    i_pred_req = 1'b1;
    i_pred_pc  = pc;
    step();
    i_pred_req = 1'b0;
  endtask

  task automatic wait_pred_start(input string tag);
    for (int i = 0; i < 20 && !o_start_pred; i++) step();
    chk(tag, 32'(o_start_pred), 32'd1);
  endtask

  task automatic push_res(input logic [W-1:0] pc, input logic tk, input logic [W-1:0] tgt);
    i_res_valid = 1'b1;
    i_res_pc    = pc;
    i_res_taken = tk;
    i_res_tgt   = tgt;
    step();
    i_res_valid = 1'b0;
  endtask

  initial begin
    int nres, npred, last, nops, nresp, acc, flag;
    logic [31:0] seq;

    rst_n = 1'b0;
    i_pred_req = 1'b0; i_pred_pc = '0;
    i_res_valid = 1'b0; i_res_pc = '0; i_res_taken = 1'b0; i_res_tgt = '0;
    i_bp_pred_taken = 1'b1; i_bp_pred_tgt = 32'h2000;
    step(); step();
    chk("rst_busy",        32'(o_busy), 0);
    chk("rst_start_pred",  32'(o_start_pred), 0);
    chk("rst_resp_valid",  32'(o_pred_resp_valid), 0);
    chk("rst_pred_ready",  32'(o_pred_ready), 1);
    chk("rst_res_ready",   32'(o_res_ready), 1);
    chk("rst_bp_pc",       o_bp_pc, 0);
    rst_n = 1'b1;
    step();

    // single predict with 3-cycle response latency
    auto_en = 1'b1;
    issue_pred(32'h1000);
    chk("t2_slot_full", 32'(o_pred_ready), 0);
    wait_pred_start("t2_start");
    chk("t2_bp_pc",    o_bp_pc, 32'h1000);
    chk("t2_bp_tgt",   o_bp_tgt, 0);
    chk("t2_bp_taken", 32'(o_bp_taken), 0);
    chk("t2_busy",     32'(o_busy), 1);
    step();
    chk("t2_pulse_one", 32'(o_start_pred), 0);
    chk("t2_resp_t1",   32'(o_pred_resp_valid), 0);
    step();
    chk("t2_resp_t2",   32'(o_pred_resp_valid), 0);
    step();
    chk("t2_resp_t3",   32'(o_pred_resp_valid), 1);
    chk("t2_resp_taken", 32'(o_pred_resp_taken), 1);
    chk("t2_resp_tgt",  o_pred_resp_tgt, 32'h2000);
    chk("t2_idle_t3",   32'(o_busy), 0);
    step();
    chk("t2_resp_t4",   32'(o_pred_resp_valid), 0);

    // reset mid-WAIT aborts silently
    auto_en = 1'b0;
    issue_pred(32'h3000);
    wait_pred_start("t1_start");
    step(); step();
    chk("t1_in_wait", 32'(o_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t1_busy",       32'(o_busy), 0);
    chk("t1_bp_pc",      o_bp_pc, 0);
    chk("t1_pred_ready", 32'(o_pred_ready), 1);
    chk("t1_res_ready",  32'(o_res_ready), 1);
    chk("t1_tmo",        32'(o_timeout_err), 0);
    step();
    rst_n = 1'b1;
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    flag = 0;
    for (int i = 0; i < 6; i++) begin
      if (o_pred_resp_valid || o_busy || o_start_resolve) flag = 1;
      step();
    end
    chk("t1_no_resp", flag, 0);

    // timeout when the predictor never answers
    issue_pred(32'h4000);
    wait_pred_start("t5_start");
    for (int i = 0; i < 14; i++) step();
    chk("t5_no_tmo_14", 32'(o_timeout_err), 0);
    step();
    chk("t5_tmo_15",    32'(o_timeout_err), 1);
    chk("t5_busy_15",   32'(o_busy), 1);
    step();
    chk("t5_tmo_clear", 32'(o_timeout_err), 0);
    chk("t5_idle",      32'(o_busy), 0);
    flag = 0;
    for (int i = 0; i < 4; i++) begin
      if (o_pred_resp_valid) flag = 1;
      step();
    end
    chk("t5_no_resp", flag, 0);

    // FIFO overflow: 5 pushes while stalled, 4 kept
    do_reset();
    issue_pred(32'h5000);
    wait_pred_start("t3_start");
    step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t3_res_ready%0d", k), 32'(o_res_ready), (k < 4) ? 32'd1 : 32'd0);
      push_res(32'h100 + 32'(k), 1'(k & 1), 32'h9000 + 32'(k));
    end
    chk("t3_full", 32'(o_res_ready), 0);
    man_done = 1'b1; auto_en = 1'b1;
    step();
    man_done = 1'b0;
    nres = 0; npred = 0; last = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_start_resolve) begin
        if (nres < 4) begin
          chk($sformatf("t3_pc%0d", nres),  o_bp_pc, 32'h100 + 32'(nres));
          chk($sformatf("t3_tgt%0d", nres), o_bp_tgt, 32'h9000 + 32'(nres));
          chk($sformatf("t3_tk%0d", nres),  32'(o_bp_taken), 32'(nres & 1));
        end
        if (nres > 0) chk($sformatf("t3_gap%0d", nres), cyc - last, 4);
        last = cyc;
        nres++;
      end
      if (o_start_pred) npred++;
      step();
    end
    chk("t3_nres",  nres, 4);
    chk("t3_npred", npred, 0);

    // fairness: R,R,P,R,R,P under constant load
    do_reset();
    auto_en = 1'b1;
    i_res_valid = 1'b1; i_res_pc = 32'h700; i_res_taken = 1'b1; i_res_tgt = 32'hABC0;
    i_pred_req = 1'b1; i_pred_pc = 32'h6000;
    nops = 0; nresp = 0; seq = '0;
    for (int i = 0; i < 60 && nops < 6; i++) begin
      step();
      if (o_pred_resp_valid) nresp++;
      if (o_start_pred) begin
        seq[nops] = 1'b1;
        chk($sformatf("t4_p_tgt%0d", nops), o_bp_tgt, 0);
        chk($sformatf("t4_p_pc%0d", nops),  o_bp_pc, 32'h6000);
        nops++;
      end else if (o_start_resolve) begin
        chk($sformatf("t4_r_tgt%0d", nops), o_bp_tgt, 32'hABC0);
        nops++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (o_pred_resp_valid) nresp++;
    end
    i_res_valid = 1'b0; i_pred_req = 1'b0;
    chk("t4_nops",  nops, 6);
    chk("t4_seq",   seq, 32'b100100);
    chk("t4_nresp", nresp, 2);

    // push+pop in the same cycle at count 2
    do_reset();
    issue_pred(32'h8000);
    wait_pred_start("t6_start");
    step();
    push_res(32'hA0, 1'b0, 32'h1);
    push_res(32'hA1, 1'b0, 32'h1);
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    chk("t6_resp",      32'(o_pred_resp_valid), 1);
    chk("t6_ready_pp",  32'(o_res_ready), 1);
    push_res(32'hA2, 1'b0, 32'h1);
    chk("t6_start_res", 32'(o_start_resolve), 1);
    chk("t6_pop_pc",    o_bp_pc, 32'hA0);
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      if (o_res_ready) begin
        i_res_valid = 1'b1;
        i_res_pc = 32'hA3 + 32'(acc);
        acc++;
      end else begin
        i_res_valid = 1'b0;
      end
      step();
    end
    i_res_valid = 1'b0;
    chk("t6_accepted", acc, 2);
    man_done = 1'b1; auto_en = 1'b1;
    step();
    man_done = 1'b0;
    nres = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_start_resolve) begin
        if (nres < 4) chk($sformatf("t6_pc%0d", nres), o_bp_pc, 32'hA1 + 32'(nres));
        nres++;
      end
      step();
    end
    chk("t6_nres", nres, 4);

    // spurious done while idle
    man_done = 1'b1;
    step(); step();
    man_done = 1'b0;
    chk("t6_sp_busy",  32'(o_busy), 0);
    chk("t6_sp_resp",  32'(o_pred_resp_valid), 0);
    chk("t6_sp_start", 32'(o_start_pred | o_start_resolve), 0);
    chk("t6_sp_tmo",   32'(o_timeout_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
